ctrl_pipe: RTL and testbench

- Pipelined carrier for the decoded control word in the 5-stage MIPS core. Takes the ID-stage control bundle and register fields and advances them through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles. Flushes on jump and taken branch.
- Generates EX-stage forwarding selects.
- Sits between the opcode decoder and the datapath stage registers.

---
 rtl/ctrl_pipe.sv | 178 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control-word carrier for the 5-stage MIPS pipeline: moves decoded control
// through ID/EX, EX/MEM and MEM/WB, with load-use stall, flush and EX forwarding.
module ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              ex_branch_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              ex_alusrc_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_branch_o,
  output logic [REG_AW-1:0] ex_wreg_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic [REG_AW-1:0] mem_wreg_o,
  output logic              wb_regwrite_o,
  output logic              wb_memtoreg_o,
  output logic [REG_AW-1:0] wb_wreg_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  localparam int B_REGDST   = 10;
  localparam int B_ALUSRC   = 9;
  localparam int B_MEMTOREG = 8;
  localparam int B_REGWRITE = 7;
  localparam int B_MEMREAD  = 6;
  localparam int B_MEMWRITE = 5;
  localparam int B_BRANCH   = 4;
  localparam int B_JUMP     = 3;
  localparam int B_EXTOP    = 2;

  typedef struct packed {
    logic              regdst;
    logic              alusrc;
    logic              memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic [1:0]        aluop;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] wreg;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic [REG_AW-1:0] ex_wreg;
  logic              load_use;
  logic              id_jump;
  logic              load_id;
  logic              unused_extop;

  // ExtOp steers the immediate extender in ID; nothing downstream needs it.
  assign unused_extop = id_ctrl_i[B_EXTOP];

  assign ex_wreg = idex_q.regdst ? idex_q.rd : idex_q.rt;
  assign id_jump = id_valid_i & id_ctrl_i[B_JUMP];

  assign load_use = idex_q.memread & (ex_wreg != '0) & id_valid_i &
                    ((ex_wreg == id_rs_i) | (ex_wreg == id_rt_i));

  // Taken branch outranks the stall so the target fetch is not held back.
  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    load_id      = id_valid_i;
    if (ex_branch_taken_i) begin
      ifid_flush_o = 1'b1;
      load_id      = 1'b0;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      load_id      = 1'b0;
    end else if (id_jump) begin
      ifid_flush_o = 1'b1;
      load_id      = 1'b0;
    end
  end

  always_comb begin
    idex_d = '0;
    if (load_id) begin
      idex_d.regdst   = id_ctrl_i[B_REGDST];
      idex_d.alusrc   = id_ctrl_i[B_ALUSRC];
      idex_d.memtoreg = id_ctrl_i[B_MEMTOREG];
      idex_d.regwrite = id_ctrl_i[B_REGWRITE];
      idex_d.memread  = id_ctrl_i[B_MEMREAD];
      idex_d.memwrite = id_ctrl_i[B_MEMWRITE];
      idex_d.branch   = id_ctrl_i[B_BRANCH];
      idex_d.aluop    = id_ctrl_i[1:0];
      idex_d.rs       = id_rs_i;
      idex_d.rt       = id_rt_i;
      idex_d.rd       = id_rd_i;
    end
  end

  always_comb begin
    exmem_d.memtoreg = idex_q.memtoreg;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.wreg     = ex_wreg;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.wreg     = exmem_q.wreg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Operand 0 is rs (A), operand 1 is rt (B); EX/MEM is the younger result.
  logic [1:0] fwd_sel [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_AW-1:0] src;
      logic              hit_mem;
      logic              hit_wb;
      assign src     = (gi == 0) ? idex_q.rs : idex_q.rt;
      assign hit_mem = exmem_q.regwrite & (exmem_q.wreg != '0) & (exmem_q.wreg == src);
      assign hit_wb  = memwb_q.regwrite & (memwb_q.wreg != '0) & (memwb_q.wreg == src);
      assign fwd_sel[gi] = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
    end
  endgenerate

  assign fwd_a_o = fwd_sel[0];
  assign fwd_b_o = fwd_sel[1];

  assign ex_alusrc_o    = idex_q.alusrc;
  assign ex_aluop_o     = idex_q.aluop;
  assign ex_branch_o    = idex_q.branch;
  assign ex_wreg_o      = ex_wreg;
  assign mem_memread_o  = exmem_q.memread;
  assign mem_memwrite_o = exmem_q.memwrite;
  assign mem_wreg_o     = exmem_q.wreg;
  assign wb_regwrite_o  = memwb_q.regwrite;
  assign wb_memtoreg_o  = memwb_q.memtoreg;
  assign wb_wreg_o      = memwb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed MIPS sequences then random traffic, checked
// against an instruction-level model of the three downstream stages.
module tb_ctrl_pipe;
  localparam int AW = 5;
  localparam int CW = 11;

  localparam logic [CW-1:0] OP_ADD = 11'b100_1000_0010;
  localparam logic [CW-1:0] OP_LW  = 11'b011_1100_0100;
  localparam logic [CW-1:0] OP_SW  = 11'b010_0010_0100;
  localparam logic [CW-1:0] OP_BEQ = 11'b000_0001_0001;
  localparam logic [CW-1:0] OP_J   = 11'b000_0000_1000;
  localparam logic [CW-1:0] OP_ORI = 11'b010_1000_0011;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] id_ctrl;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          br_taken;
  logic          pc_write, ifid_write, ifid_flush;
  logic          ex_alusrc, ex_branch;
  logic [1:0]    ex_aluop;
  logic [AW-1:0] ex_wreg, mem_wreg, wb_wreg;
  logic          mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic [1:0]    fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(AW), .CTRL_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_ctrl_i(id_ctrl), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .ex_branch_taken_i(br_taken),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .ex_alusrc_o(ex_alusrc), .ex_aluop_o(ex_aluop), .ex_branch_o(ex_branch),
    .ex_wreg_o(ex_wreg),
    .mem_memread_o(mem_memread), .mem_memwrite_o(mem_memwrite), .mem_wreg_o(mem_wreg),
    .wb_regwrite_o(wb_regwrite), .wb_memtoreg_o(wb_memtoreg), .wb_wreg_o(wb_wreg),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
  );

  // One record per instruction; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [AW-1:0] rs, rt, rd;
  } instr_t;

  instr_t pipe [3];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] ops [6];

  function automatic logic [AW-1:0] dest(instr_t i);
    return i.ctrl[10] ? i.rd : i.rt;
  endfunction

  function automatic logic writes(instr_t i);
    return i.ctrl[7];
  endfunction

  function automatic logic [1:0] fwd_of(logic [AW-1:0] src);
    if (writes(pipe[1]) && dest(pipe[1]) != 0 && dest(pipe[1]) == src) return 2'b10;
    if (writes(pipe[2]) && dest(pipe[2]) != 0 && dest(pipe[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic stall_now();
    logic [AW-1:0] d;
    d = dest(pipe[0]);
    return pipe[0].ctrl[6] && d != 0 && id_valid && (d == id_rs || d == id_rt);
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic lu, exp_flush, exp_pc;
    lu = stall_now();
    exp_pc    = br_taken || !lu;
    exp_flush = br_taken || (!lu && id_valid && id_ctrl[3]);
    check("pc_write",     8'(pc_write),     8'(exp_pc));
    check("ifid_write",   8'(ifid_write),   8'(exp_pc));
    check("ifid_flush",   8'(ifid_flush),   8'(exp_flush));
    check("ex_alusrc",    8'(ex_alusrc),    8'(pipe[0].ctrl[9]));
    check("ex_aluop",     8'(ex_aluop),     8'(pipe[0].ctrl[1:0]));
    check("ex_branch",    8'(ex_branch),    8'(pipe[0].ctrl[4]));
    check("ex_wreg",      8'(ex_wreg),      8'(dest(pipe[0])));
    check("mem_memread",  8'(mem_memread),  8'(pipe[1].ctrl[6]));
    check("mem_memwrite", 8'(mem_memwrite), 8'(pipe[1].ctrl[5]));
    check("mem_wreg",     8'(mem_wreg),     8'(dest(pipe[1])));
    check("wb_regwrite",  8'(wb_regwrite),  8'(pipe[2].ctrl[7]));
    check("wb_memtoreg",  8'(wb_memtoreg),  8'(pipe[2].ctrl[8]));
    check("wb_wreg",      8'(wb_wreg),      8'(dest(pipe[2])));
    check("fwd_a",        8'(fwd_a),        8'(fwd_of(pipe[0].rs)));
    check("fwd_b",        8'(fwd_b),        8'(fwd_of(pipe[0].rt)));
  endtask

  task automatic drive(logic [CW-1:0] c, logic v, logic [AW-1:0] rs, logic [AW-1:0] rt,
                       logic [AW-1:0] rd, logic br);
    @(negedge clk);
    id_ctrl = c; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; br_taken = br;
    #1;
    check_all();
    $display("t=%0t ctrl=%b v=%0d rs=%0d rt=%0d rd=%0d br=%0d pc_w=%0d flush=%0d fwd=%0d/%0d",
             $time, c, v, rs, rt, rd, br, pc_write, ifid_flush, fwd_a, fwd_b);
  endtask

  task automatic tick();
    instr_t nxt;
    logic enter;
    @(posedge clk);
    enter = id_valid && !br_taken && !stall_now() && !id_ctrl[3];
    nxt = enter ? instr_t'{id_ctrl, id_rs, id_rt, id_rd} : '0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = rst ? '0 : nxt;
    if (rst) begin
      pipe[1] = '0;
      pipe[2] = '0;
    end
  endtask

  task automatic step(logic [CW-1:0] c, logic v, logic [AW-1:0] rs, logic [AW-1:0] rt,
                      logic [AW-1:0] rd, logic br);
    drive(c, v, rs, rt, rd, br);
    tick();
  endtask

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_J;  ops[5] = OP_ORI;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    rst = 1'b1;
    id_ctrl = '0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // lw $2,0($1) ; add $3,$2,$4 -> one stall, then MEM/WB forward
    step(OP_LW, 1, 1, 2, 0, 0);
    drive(OP_ADD, 1, 2, 4, 3, 0);
    check("lu_pc_write", 8'(pc_write), 8'd0);
    check("lu_ifid_write", 8'(ifid_write), 8'd0);
    tick();
    drive(OP_ADD, 1, 2, 4, 3, 0);
    check("lu_bubble_wreg", 8'(ex_wreg), 8'd0);
    check("lu_bubble_aluop", 8'(ex_aluop), 8'd0);
    check("lu_no_restall", 8'(pc_write), 8'd1);
    tick();
    drive('0, 0, 0, 0, 0, 0);
    check("lu_fwd_a", 8'(fwd_a), 8'b01);
    tick();

    // add $5,$1,$1 ; sub $6,$5,$5 -> EX/MEM forward on both, no stall
    step(OP_ADD, 1, 1, 1, 5, 0);
    drive(OP_ADD, 1, 5, 5, 6, 0);
    check("alu_no_stall", 8'(pc_write), 8'd1);
    tick();
    drive('0, 0, 0, 0, 0, 0);
    check("alu_fwd_a", 8'(fwd_a), 8'b10);
    check("alu_fwd_b", 8'(fwd_b), 8'b10);
    tick();

    // ori $7 in WB, add $7 in MEM, consumer of $7 in EX -> EX/MEM wins
    step(OP_ORI, 1, 0, 7, 0, 0);
    step(OP_ADD, 1, 1, 1, 7, 0);
    step(OP_ADD, 1, 7, 0, 8, 0);
    drive('0, 0, 0, 0, 0, 0);
    check("dbl_fwd_a", 8'(fwd_a), 8'b10);
    tick();

    // taken branch coinciding with a load-use pair
    step(OP_LW, 1, 1, 2, 0, 0);
    drive(OP_ADD, 1, 2, 4, 3, 1);
    check("br_flush", 8'(ifid_flush), 8'd1);
    check("br_pc_write", 8'(pc_write), 8'd1);
    tick();
    drive('0, 0, 0, 0, 0, 0);
    check("br_bubble_wreg", 8'(ex_wreg), 8'd0);
    tick();

    // beq proceeds to MEM without MemWrite
    step(OP_BEQ, 1, 1, 3, 0, 0);
    drive('0, 0, 0, 0, 0, 1);
    check("beq_ex_branch", 8'(ex_branch), 8'd1);
    tick();
    drive('0, 0, 0, 0, 0, 0);
    check("beq_mem_memwrite", 8'(mem_memwrite), 8'd0);
    tick();

    // j in ID flushes and enters as a bubble
    drive(OP_J, 1, 0, 0, 0, 0);
    check("j_flush", 8'(ifid_flush), 8'd1);
    tick();
    drive('0, 0, 0, 0, 0, 0);
    check("j_ex_aluop", 8'(ex_aluop), 8'd0);
    check("j_flush_one", 8'(ifid_flush), 8'd0);
    tick();

    // load into $0 is never a hazard
    step(OP_LW, 1, 1, 0, 0, 0);
    drive(OP_ADD, 1, 0, 0, 3, 0);
    check("r0_no_stall", 8'(pc_write), 8'd1);
    tick();

    // async reset with lw in MEM
    step(OP_LW, 1, 1, 9, 0, 0);
    step('0, 0, 0, 0, 0, 0);
    @(negedge clk);
    id_ctrl = '0; id_valid = 1'b0; br_taken = 1'b0;
    check("pre_rst_memread", 8'(mem_memread), 8'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    check("rst_memread", 8'(mem_memread), 8'd0);
    check_all();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pc_write", 8'(pc_write), 8'd1);
    check_all();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [CW-1:0] c;
      c = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 5)] : CW'($urandom);
      step(c, ($urandom_range(0, 9) != 0),
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
